// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state
// encoding and the common reset/step constants of the fetch front end.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          STEP_RV32I       = 4;
  localparam int          STEP_RVC         = 2;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues one PC per accepted handshake,
// supports redirects, run enable, halt-after-N-issues and flags PCs
// that are not aligned to STEP.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              STEP       = STEP_RV32I,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEFAULT_RESET_PC),
  parameter int              SEQ_W      = 20,
  parameter int              HALT_COUNT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [SEQ_W-1:0] out_seq,
  output logic [XLEN-1:0]  out_prev_pc,
  output logic             halted,
  output logic             misaligned
);

  // The issue counter must reach HALT_COUNT even when out_seq is narrower.
  localparam int HC_W  = $clog2(HALT_COUNT + 1);
  localparam int CNT_W = (SEQ_W > HC_W) ? SEQ_W : HC_W;

  state_t             state, state_n;
  logic [XLEN-1:0]    pc_n, prev_n;
  logic [SEQ_W-1:0]   seq_n;
  logic [CNT_W-1:0]   count, count_n;
  logic               valid_n, halted_n;
  logic               transfer;
  logic [XLEN-1:0]    step_pc;

  assign transfer = out_valid && out_ready;
  assign step_pc  = out_pc + XLEN'(STEP);

  // Next-state and next-output decode; redirect beats +STEP beats hold.
  always_comb begin
    state_n  = state;
    pc_n     = out_pc;
    prev_n   = out_prev_pc;
    seq_n    = out_seq;
    count_n  = count;
    valid_n  = out_valid;
    halted_n = halted;
    case (state)
      IDLE: begin
        if (redirect_valid) pc_n = redirect_pc;
        if (en) begin
          state_n = RUN;
          valid_n = 1'b1;
        end
      end
      RUN, HOLD: begin
        if (transfer) begin
          prev_n  = out_pc;
          seq_n   = out_seq + SEQ_W'(1);
          count_n = count + CNT_W'(1);
          pc_n    = redirect_valid ? redirect_pc : step_pc;
          if ((HALT_COUNT != 0) && (count_n == CNT_W'(HALT_COUNT))) begin
            state_n  = HALT;
            valid_n  = 1'b0;
            halted_n = 1'b1;
          end else if (!en) begin
            state_n = IDLE;
            valid_n = 1'b0;
          end else begin
            state_n = RUN;
          end
        end else begin
          // Stalled: a redirect squashes the presented PC without counting it.
          if (redirect_valid) pc_n = redirect_pc;
          state_n = HOLD;
        end
      end
      HALT: begin
        state_n = HALT;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_pc      <= RESET_PC;
      out_prev_pc <= RESET_PC;
      out_seq     <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_n;
      out_pc      <= pc_n;
      out_prev_pc <= prev_n;
      out_seq     <= seq_n;
      count       <= count_n;
      out_valid   <= valid_n;
      halted      <= halted_n;
    end
  end

  // Alignment flag looks only at the low bits below the step size.
  if (STEP > 1) begin : g_align
    assign misaligned = |out_pc[$clog2(STEP)-1:0];
  end else begin : g_no_align
    assign misaligned = 1'b0;
  end

endmodule
